traffic_ctrl_2way: RTL
======================

Name: traffic_ctrl_2way

Overview:
- Parametrised two-road intersection controller that generalises the single-signal red/yellow/green sequencer.
- Drives two signal heads, north-south (NS) and east-west (EW), with a separate all-red clearance phase between them.
- Adds a pedestrian walk request that can cut green short after a minimum green time, and a flashing-yellow maintenance mode.
- Sits at the top of the traffic subsystem, directly driving the lamp outputs. A single shared phase timer replaces the three per-colour counter/comparator pairs.

Parameters:
- CNT_W, 8: width of the phase timer. Every duration must be < 2**CNT_W.
- GRN_T, 4: green duration in cycles. Must be >= 1.
- YEL_T, 1: yellow duration in cycles. Must be >= 1.
- RED_CLR_T, 2: all-red clearance duration in cycles. Must be >= 1.
- MIN_GRN_T, 2: minimum green time before a pedestrian request may end green. Range 1..GRN_T.
- PED_T, 3: all-red duration when a pedestrian walk is served. Must be >= 1.
- FLASH_T, 2: half-period of the flashing yellow, in cycles. Must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level. Leaves IDLE when high; ignored in all other states.
- ped_req  in  1  pedestrian request. A single-cycle pulse is sufficient; it is latched internally.
- flash_mode  in  1  level. Selects maintenance flashing-yellow mode.
- ns_red, ns_yel, ns_grn  out  1 each  NS signal lamps.
- ew_red, ew_yel, ew_grn  out  1 each  EW signal lamps.
- ped_walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding, for debug and status.

Behaviour:
- Reset: synchronous; rst wins over every other input.
  - After reset: state=IDLE, timer=0, ped_pend=0, flash toggle=0.
  - Output values: ns_red=ew_red=1, all other lamps=0, ped_walk=0, phase=IDLE.
- Outputs are Moore outputs, decoded from the registered state only. No input-to-output combinational path exists.
- States and their encodings:
  - IDLE(0): both heads red.
  - NS_GRN(1), NS_YEL(2), AR1(3): NS green, NS yellow, then all-red clearance.
  - EW_GRN(4), EW_YEL(5), AR2(6): EW green, EW yellow, then all-red clearance.
  - FLASH(7): maintenance mode.
- Timer rules:
  - The timer is cleared to 0 on every state entry and increments by 1 each cycle.
  - A state of duration T exits on the cycle where timer==T-1, so each state lasts exactly T cycles.
- Normal sequence: IDLE -(start)-> NS_GRN -> NS_YEL -> AR1 -> EW_GRN -> EW_YEL -> AR2 -> NS_GRN, repeating.
- Lamp decode:
  - The red lamp of the non-green head stays on throughout.
  - AR1, AR2 and IDLE drive both red lamps.
- Pedestrian handling:
  - ped_pend is set when ped_req=1 in any non-FLASH state.
  - In NS_GRN or EW_GRN, if (ped_pend or ped_req) and timer >= MIN_GRN_T-1, green ends that cycle and the head moves to its YEL state.
  - Otherwise green ends at GRN_T.
  - The AR state following a served request lasts PED_T instead of RED_CLR_T and drives ped_walk=1 for its whole duration.
  - ped_pend clears on entry to that AR state.
  - A ped_req arriving during the walk AR is latched and served on the next green.
  - A request arriving during yellow does not change that yellow. It is carried into the next green.
- Flash mode:
  - flash_mode=1 in any state except IDLE forces the next state to FLASH. It takes priority over timer expiry and ped_req.
  - In FLASH, ns_yel=ew_yel=toggle. The toggle inverts every FLASH_T cycles (timer wraps at FLASH_T-1), starting at 1 on entry. All red, green and walk lamps are 0.
  - ped_req is ignored in FLASH, and ped_pend is cleared on FLASH entry.
  - When flash_mode drops, FLASH goes to AR2 with RED_CLR_T duration, then NS_GRN.
  - flash_mode in IDLE has no effect until start.
- Simultaneous events:
  - Priority order is rst > flash_mode > timer expiry/ped early-termination.
  - When ped_req coincides with natural green expiry, the walk is still served in the following AR.
- Width: the timer saturates at 2**CNT_W-1. Overflow is unreachable given the legal parameter ranges.
- Assertions (simulation only):
  - Both heads are never non-red simultaneously.
  - At most one lamp per head is on.

Decomposition:
- Package traffic_pkg contains:
  - the state enum type traffic_state_t with the encodings above;
  - default duration constants;
  - a function that returns the duration of a state given the ped flag.
- One sub-module, phase_timer, is natural. It is a CNT_W-bit counter with sync clear and terminal-compare input, and outputs a done flag (count==limit-1). It replaces the separate counter and comparator instances.

Test Plan:
- Defaults, reset for 2 cycles, then start=1 at cycle 0 → NS_GRN cycles 1-4, NS_YEL cycle 5, AR1 cycles 6-7, EW_GRN 8-11, EW_YEL 12, AR2 13-14, NS_GRN again at 15.
- ped_req pulse on the first NS_GRN cycle → green lasts 2 cycles, NS_YEL for 1, then AR1 for 3 cycles with ped_walk=1; EW_GRN follows with full length 4.
- flash_mode=1 during EW_GRN → FLASH next cycle; yellow pattern 1,1,0,0,1,1 on both heads; after deassert → AR2 for 2 cycles, then NS_GRN.
- rst=1 mid-EW_YEL for 1 cycle → next cycle phase=0, both reds=1, ped_walk=0; no progress until start.
- ped_req held during NS_YEL → no change to that yellow; the request is served on EW_GRN, which ends at cycle MIN_GRN_T, followed by a 3-cycle walk AR2.
- Parameter sweep GRN_T=MIN_GRN_T=1, YEL_T=1, RED_CLR_T=1 → 6-cycle loop; safety assertions never fire over 1000 random ped_req/flash_mode cycles.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way traffic controller.
//   traffic_state_t : controller state, encoding is also the debug phase output
//   DEF_*           : default phase durations in cycles
//   state_dur()     : duration of a state; all-red is longer when a walk is served
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NS_GRN = 3'd1,
    NS_YEL = 3'd2,
    AR1    = 3'd3,
    EW_GRN = 3'd4,
    EW_YEL = 3'd5,
    AR2    = 3'd6,
    FLASH  = 3'd7
  } traffic_state_t;

  localparam int DEF_GRN_T     = 4;
  localparam int DEF_YEL_T     = 1;
  localparam int DEF_RED_CLR_T = 2;
  localparam int DEF_MIN_GRN_T = 2;
  localparam int DEF_PED_T     = 3;
  localparam int DEF_FLASH_T   = 2;

  // IDLE has no timed exit, so it reports 0 (its done flag is never consulted).
  function automatic int state_dur(traffic_state_t st, logic walk,
                                   int grn_t = DEF_GRN_T, int yel_t = DEF_YEL_T,
                                   int red_clr_t = DEF_RED_CLR_T, int ped_t = DEF_PED_T,
                                   int flash_t = DEF_FLASH_T);
    case (st)
      NS_GRN, EW_GRN: return grn_t;
      NS_YEL, EW_YEL: return yel_t;
      AR1, AR2:       return walk ? ped_t : red_clr_t;
      FLASH:          return flash_t;
      default:        return 0;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_2way_phase_timer.sv
// Shared phase timer: counts cycles since the last clear and flags the final
// cycle of a phase.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at 0 next cycle
//   limit    : duration of the current phase
//   count    : cycles elapsed in the phase (saturating)
//   done     : count == limit-1, i.e. last cycle of the phase
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (clr)           count <= '0;
    else if (count != '1)   count <= count + CNT_W'(1);
  end

  assign done = (count == limit - CNT_W'(1));

endmodule

// File: rtl/traffic_ctrl_2way.sv
// Two-road intersection controller: NS and EW heads with all-red clearance,
// pedestrian early-green termination with walk phase, and flashing-yellow
// maintenance mode. All outputs are decoded from registered state.
//   clk, rst         : clock, synchronous active-high reset
//   start            : leaves IDLE
//   ped_req          : pedestrian request pulse (latched)
//   flash_mode       : maintenance flashing yellow
//   ns_*/ew_* lamps  : signal heads
//   ped_walk         : walk lamp, on during a served all-red
//   phase            : current state encoding
module traffic_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int GRN_T     = DEF_GRN_T,
  parameter int YEL_T     = DEF_YEL_T,
  parameter int RED_CLR_T = DEF_RED_CLR_T,
  parameter int MIN_GRN_T = DEF_MIN_GRN_T,
  parameter int PED_T     = DEF_PED_T,
  parameter int FLASH_T   = DEF_FLASH_T
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic       ns_red,
  output logic       ns_yel,
  output logic       ns_grn,
  output logic       ew_red,
  output logic       ew_yel,
  output logic       ew_grn,
  output logic       ped_walk,
  output logic [2:0] phase
);

  traffic_state_t   state, nxt;
  logic             ped_pend;  // request waiting for a green to serve it
  logic             serve;     // the green just ended serves a walk
  logic             walk;      // current all-red is a walk phase
  logic             toggle;    // flashing yellow level
  logic [CNT_W-1:0] limit, count;
  logic             done, clr;
  logic             ped_any, is_grn, is_yel, walk_entry;

  assign limit   = CNT_W'(state_dur(state, walk, GRN_T, YEL_T, RED_CLR_T, PED_T, FLASH_T));
  assign ped_any = ped_pend | ped_req;
  assign is_grn  = (state == NS_GRN) || (state == EW_GRN);
  assign is_yel  = (state == NS_YEL) || (state == EW_YEL);
  // Yellow -> all-red after a served green opens the walk phase.
  assign walk_entry = is_yel && serve && (nxt != state);
  // FLASH restarts its timer every half-period to drive the toggle.
  assign clr = (nxt != state) || ((state == FLASH) && done);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .limit (limit),
    .count (count),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (state == IDLE) begin
      if (start) nxt = NS_GRN;
    end else if (flash_mode) begin
      nxt = FLASH;
    end else begin
      case (state)
        NS_GRN: if (done || (ped_any && count >= CNT_W'(MIN_GRN_T-1))) nxt = NS_YEL;
        NS_YEL: if (done) nxt = AR1;
        AR1:    if (done) nxt = EW_GRN;
        EW_GRN: if (done || (ped_any && count >= CNT_W'(MIN_GRN_T-1))) nxt = EW_YEL;
        EW_YEL: if (done) nxt = AR2;
        AR2:    if (done) nxt = NS_GRN;
        FLASH:  nxt = AR2;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend <= 1'b0;
      serve    <= 1'b0;
      walk     <= 1'b0;
      toggle   <= 1'b0;
    end else begin
      // A new request wins over the walk-entry clear so a request on the
      // last yellow cycle carries into the next green.
      if (nxt == FLASH)        ped_pend <= 1'b0;
      else if (state != FLASH) ped_pend <= (ped_pend & ~walk_entry) | ped_req;

      if (is_grn && nxt != state) serve <= ped_any;
      if (nxt != state)           walk  <= walk_entry;

      if (nxt == FLASH && state != FLASH) toggle <= 1'b1;
      else if (state == FLASH && done)    toggle <= ~toggle;
    end
  end

  always_comb begin
    ns_red   = 1'b0;
    ns_yel   = 1'b0;
    ns_grn   = 1'b0;
    ew_red   = 1'b0;
    ew_yel   = 1'b0;
    ew_grn   = 1'b0;
    ped_walk = 1'b0;
    case (state)
      NS_GRN: begin ns_grn = 1'b1; ew_red = 1'b1; end
      NS_YEL: begin ns_yel = 1'b1; ew_red = 1'b1; end
      EW_GRN: begin ew_grn = 1'b1; ns_red = 1'b1; end
      EW_YEL: begin ew_yel = 1'b1; ns_red = 1'b1; end
      AR1, AR2: begin ns_red = 1'b1; ew_red = 1'b1; ped_walk = walk; end
      FLASH:  begin ns_yel = toggle; ew_yel = toggle; end
      default: begin ns_red = 1'b1; ew_red = 1'b1; end
    endcase
  end

  assign phase = state;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state != FLASH) assert (!((ns_yel | ns_grn) && (ew_yel | ew_grn)));
      assert ($countones({ns_red, ns_yel, ns_grn}) <= 1);
      assert ($countones({ew_red, ew_yel, ew_grn}) <= 1);
    end
  end
`endif

endmodule
